// File: rtl/spi_arb_if.sv
// Link between the arbiter and the shared SPI_mstr16: launch handshake,
// read-back data, the master's slave select and the muxed MISO.
interface spi_arb_if;
    logic        m_wrt;
    logic [15:0] m_cmd;
    logic        m_done;
    logic [15:0] m_rd_data;
    logic        m_SS_n;
    logic        m_MISO;

    // Arbiter side: launches transactions and feeds MISO to the master.
    modport master (
        output m_wrt, m_cmd, m_MISO,
        input  m_done, m_rd_data, m_SS_n
    );

    // SPI master side.
    modport slave (
        input  m_wrt, m_cmd, m_MISO,
        output m_done, m_rd_data, m_SS_n
    );
endinterface

// File: rtl/spi_arb.sv
// Two-requester arbiter sharing one SPI_mstr16 between the inertial sensor
// (requester 0) and the A2D (requester 1). Each requester owns a single
// pending slot; ties alternate, and a transaction that never completes is
// aborted after TO_CYC cycles with an err pulse.
module spi_arb #(
    parameter int unsigned TO_CYC = 2047
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt0,
    input  logic [15:0] cmd0,
    input  logic        wrt1,
    input  logic [15:0] cmd1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] rd_data0,
    output logic [15:0] rd_data1,
    spi_arb_if.master   bus,
    output logic        SS0_n,
    output logic        SS1_n,
    input  logic        MISO0,
    input  logic        MISO1
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY
    } state_t;

    // Last counter value of a transaction that is still allowed to finish.
    localparam logic [11:0] TO_LAST = 12'(TO_CYC - 1);

    state_t      state;
    logic [1:0]  pend;
    logic [15:0] cmd_q0;
    logic [15:0] cmd_q1;
    logic        last_gnt;
    logic        sel;
    logic [11:0] cnt;
    logic        gnt;

    // Pick the requester to serve from IDLE: the lone pending one, or on a tie
    // the one that was not served last.
    always_comb begin
        gnt = 1'b0;
        if (pend == 2'b11)
            gnt = ~last_gnt;
        else
            gnt = pend[1];
    end

    // Request slots, arbitration FSM, timeout counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            cmd_q0    <= '0;
            cmd_q1    <= '0;
            last_gnt  <= 1'b1;
            sel       <= 1'b0;
            cnt       <= '0;
            bus.m_wrt <= 1'b0;
            bus.m_cmd <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rd_data0  <= '0;
            rd_data1  <= '0;
        end else begin
            bus.m_wrt <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;

            // A full slot ignores further pulses, so the latched command is never overwritten.
            if (wrt0 && !pend[0]) begin
                pend[0] <= 1'b1;
                cmd_q0  <= cmd0;
            end
            if (wrt1 && !pend[1]) begin
                pend[1] <= 1'b1;
                cmd_q1  <= cmd1;
            end

            case (state)
                IDLE: begin
                    if (pend != 2'b00) begin
                        sel       <= gnt;
                        last_gnt  <= gnt;
                        bus.m_wrt <= 1'b1;
                        bus.m_cmd <= gnt ? cmd_q1 : cmd_q0;
                        cnt       <= '0;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // The slot is still full here, so this clear cannot race a new capture.
                    pend[sel] <= 1'b0;
                    cnt       <= cnt + 12'd1;
                    state     <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt + 12'd1;
                    if (bus.m_done) begin
                        if (sel) begin
                            rd_data1 <= bus.m_rd_data;
                            done1    <= 1'b1;
                        end else begin
                            rd_data0 <= bus.m_rd_data;
                            done0    <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (cnt == TO_LAST) begin
                        if (sel)
                            err1 <= 1'b1;
                        else
                            err0 <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route the master's slave select and the device's MISO only while a
    // transaction owns the bus; otherwise both devices stay deselected.
    always_comb begin
        SS0_n      = 1'b1;
        SS1_n      = 1'b1;
        bus.m_MISO = 1'b0;
        if (state != IDLE) begin
            if (sel) begin
                SS1_n      = bus.m_SS_n;
                bus.m_MISO = MISO1;
            end else begin
                SS0_n      = bus.m_SS_n;
                bus.m_MISO = MISO0;
            end
        end
    end

endmodule
